// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_pkg
//  Description : Shared types and constants for the LC-3 memory-access stage:
//                controller state encoding, selMDR source codes and default
//                widths/timeout.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3_mem_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // selMDR source codes; 2'b10 and 2'b11 are reserved and load nothing
    localparam logic [1:0] SEL_MDR_BUS = 2'b00;
    localparam logic [1:0] SEL_MDR_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mem_state_e;

    // True in the states that hold a request on the memory port
    function automatic logic is_access(input mem_state_e s);
        return (s == READ) || (s == WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl_if
//  Description : Bundles the controller strobes, MAR/MDR views and the
//                external memory request/acknowledge port of lc3_mem_ctrl.
//                slave  : the memory-access stage (lc3_mem_ctrl)
//                master : controller + memory side (drives strobes, rdata/ack)
//  Revision    : 1.0  initial release
// ============================================================================
interface lc3_mem_ctrl_if
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // controller side
    logic [DATA_W-1:0] bus;
    logic              ldMAR;
    logic              ldMDR;
    logic [1:0]        selMDR;
    logic              memWE;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              mem_ready;
    logic              mem_err;
    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  bus, ldMAR, ldMDR, selMDR, memWE, mem_rdata, mem_ack,
        output mar, mdr, mem_ready, mem_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output bus, ldMAR, ldMDR, selMDR, memWE, mem_rdata, mem_ack,
        input  mar, mdr, mem_ready, mem_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/lc3_mem_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_timeout
//  Description : Wait-cycle counter for a pending memory request. Cleared when
//                a new access starts, counts every request cycle without an
//                acknowledge, and flags expiry in the cycle whose edge would
//                bring the count to TIMEOUT_CYCLES. An ack in that same cycle
//                suppresses the expiry.
//  Ports       : clk, rst (async, active-high)
//                i_clear  - a new access starts this cycle
//                i_busy   - request currently held on the memory port
//                i_ack    - memory acknowledge
//                o_expire - abort the access at the next edge
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 64
)(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_busy,
    input  wire logic i_ack,
    output logic      o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_busy && !i_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_busy && !i_ack && (r_cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_ctrl
//  Description : LC-3 memory-access stage. Holds MAR/MDR, converts the
//                controller's ldMAR/ldMDR/selMDR/memWE strobes into a
//                request/acknowledge transaction on the memory port and
//                returns a one-cycle mem_ready pulse when the access is done.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-high
//                bus_if - lc3_mem_ctrl_if.slave (strobes, MAR/MDR, memory port)
//  Options     : LC3_MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES
//                unacknowledged request cycles; mem_err pulses with mem_ready.
//                Undefined: accesses wait indefinitely, mem_err is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
    input  wire logic      clk,
    input  wire logic      reset,
    lc3_mem_ctrl_if.slave  bus_if
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lc3_mem_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_e        r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_mar,       w_mar_nxt;
    logic [DATA_W-1:0] r_mdr,       w_mdr_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
    logic              r_mem_req,   w_req_nxt;
    logic              r_mem_we,    w_we_nxt;
    logic              r_mem_ready, w_ready_nxt;
    logic              r_mem_err,   w_err_nxt;
    logic              r_abort,     w_abort_nxt;   // current access ended by timeout
    logic              w_expire;

`ifdef LC3_MEM_TIMEOUT_EN
    logic w_start;

    assign w_start = (r_state == IDLE) && is_access(w_state_nxt);

    lc3_mem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .i_clear  (w_start),
        .i_busy   (r_mem_req),
        .i_ack    (bus_if.mem_ack),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mar       <= w_mar_nxt;
            r_mdr       <= w_mdr_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_ready <= w_ready_nxt;
            r_mem_err   <= w_err_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mar_nxt   = r_mar;
        w_mdr_nxt   = r_mdr;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;
        w_abort_nxt = r_abort;

        case (r_state)
            IDLE: begin
                if (bus_if.ldMAR) begin
                    w_mar_nxt = ADDR_W'(bus_if.bus);
                end
                if (bus_if.ldMDR && (bus_if.selMDR == SEL_MDR_BUS)) begin
                    w_mdr_nxt = bus_if.bus;
                end
                // Address and write data come from the registers as they were
                // before this edge, so a same-cycle ldMAR/ldMDR cannot leak in.
                // A write takes priority over a simultaneous read request.
                if (bus_if.memWE) begin
                    w_addr_nxt  = r_mar;
                    w_wdata_nxt = r_mdr;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = WRITE;
                end else if (bus_if.ldMDR && (bus_if.selMDR == SEL_MDR_MEM)) begin
                    w_addr_nxt  = r_mar;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = READ;
                end
            end

            READ: begin
                if (bus_if.mem_ack) begin
                    w_mdr_nxt   = bus_if.mem_rdata;
                    w_state_nxt = DONE;
                end else if (w_expire) begin
                    w_mdr_nxt   = '0;
                    w_abort_nxt = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            WRITE: begin
                if (bus_if.mem_ack) begin
                    w_state_nxt = DONE;
                end else if (w_expire) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Port outputs are registered copies of the state being entered
        w_req_nxt   = is_access(w_state_nxt);
        w_we_nxt    = (w_state_nxt == WRITE);
        w_ready_nxt = (r_state == DONE);
        w_err_nxt   = (r_state == DONE) && r_abort;
    end

    assign bus_if.mar       = r_mar;
    assign bus_if.mdr       = r_mdr;
    assign bus_if.mem_req   = r_mem_req;
    assign bus_if.mem_we    = r_mem_we;
    assign bus_if.mem_addr  = r_mem_addr;
    assign bus_if.mem_wdata = r_mem_wdata;
    assign bus_if.mem_ready = r_mem_ready;
    assign bus_if.mem_err   = r_mem_err;

endmodule
`default_nettype wire
